// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage owning the PC and the IF/ID pipeline register.
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   imem_pc          : current PC to instruction memory (raw byte address)
//   imem_instr       : instruction returned combinationally for imem_pc
//   stall            : hold PC, IF/ID, state and fetch counter
//   redirect         : taken branch/jump from EX; wins over stall
//   redirect_pc      : redirect target (low two bits dropped, flagged if nonzero)
//   if_id_pc         : PC of the instruction held in IF/ID
//   if_id_instr      : instruction held in IF/ID (NOP_INSTR when a bubble)
//   if_id_valid      : IF/ID holds a real instruction
//   halted           : fetch stopped after seeing HALT_INSTR
//   misaligned       : sticky, some redirect target was not word aligned
//   fetch_count      : instructions written into IF/ID with valid=1
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] fetch_count
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t      state;
    logic [63:0] pc;

    assign imem_pc = pc;

    // Priority per edge: redirect > stall > halted/halt detect > normal fetch.
    // Bubbles clear if_id_pc so a flushed slot never carries a stale address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
            misaligned  <= 1'b0;
            fetch_count <= '0;
        end else if (redirect) begin
            state       <= RUN;
            halted      <= 1'b0;
            pc          <= {redirect_pc[63:2], 2'b00};
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            misaligned  <= misaligned | (|redirect_pc[1:0]);
        end else if (!stall) begin
            if (state == HALTED || imem_instr == HALT_INSTR) begin
                state       <= HALTED;
                halted      <= 1'b1;
                if_id_pc    <= '0;
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end else begin
                pc          <= pc + 64'd4;
                if_id_pc    <= pc;
                if_id_instr <= imem_instr;
                if_id_valid <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage (directed table, async reset, random vs model).
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] imem_pc;
    logic [31:0] imem_instr;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic        misaligned;
    logic [31:0] fetch_count;

    logic [31:0] mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign imem_instr = mem[imem_pc[9:2]];

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .halted(halted), .misaligned(misaligned), .fetch_count(fetch_count)
    );

    typedef struct {
        logic        s;
        logic        r;
        logic [63:0] rpc;
        logic [63:0] pc;
        logic        v;
        logic [63:0] ipc;
        logic [31:0] ins;
        logic [31:0] cnt;
        logic        h;
        logic        m;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic r, input logic [63:0] rpc);
        stall = s;
        redirect = r;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " pc"}, imem_pc, 64'd0);
        chk({tag, " ifpc"}, if_id_pc, 64'd0);
        chk({tag, " instr"}, {32'd0, if_id_instr}, 64'h13);
        chk({tag, " valid"}, {63'd0, if_id_valid}, 64'd0);
        chk({tag, " halted"}, {63'd0, halted}, 64'd0);
        chk({tag, " mis"}, {63'd0, misaligned}, 64'd0);
        chk({tag, " cnt"}, {32'd0, fetch_count}, 64'd0);
    endtask

    function automatic logic [31:0] a(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    // behavioural model state for the random phase
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_ins, m_cnt;
    logic        m_v, m_h, m_m;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = a(i);
        mem[5] = 32'h0;
        tbl.push_back('{1'b0, 1'b0, 64'h0,  64'h4,  1'b1, 64'h0,  a(0),  32'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 64'h0,  64'h8,  1'b1, 64'h4,  a(1),  32'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 64'h0,  64'h8,  1'b1, 64'h4,  a(1),  32'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 64'h0,  64'h8,  1'b1, 64'h4,  a(1),  32'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 64'h0,  64'hC,  1'b1, 64'h8,  a(2),  32'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 64'h0,  64'h10, 1'b1, 64'hC,  a(3),  32'd4, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 64'h40, 64'h40, 1'b0, 64'h0,  32'h13, 32'd4, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 64'h0,  64'h44, 1'b1, 64'h40, a(16), 32'd5, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 64'h42, 64'h40, 1'b0, 64'h0,  32'h13, 32'd5, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 64'h0,  64'h44, 1'b1, 64'h40, a(16), 32'd6, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 64'h10, 64'h10, 1'b0, 64'h0,  32'h13, 32'd6, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 64'h0,  64'h14, 1'b1, 64'h10, a(4),  32'd7, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 64'h0,  64'h14, 1'b0, 64'h0,  32'h13, 32'd7, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 64'h0,  64'h14, 1'b0, 64'h0,  32'h13, 32'd7, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 64'h0,  64'h14, 1'b0, 64'h0,  32'h13, 32'd7, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 64'h0,  64'h0,  1'b0, 64'h0,  32'h13, 32'd7, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 64'h0,  64'h4,  1'b1, 64'h0,  a(0),  32'd8, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 32'h13, 32'd8, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 64'h0,  64'h0,  1'b1, 64'hFFFF_FFFF_FFFF_FFFC, a(255), 32'd9, 1'b0, 1'b1});

        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].r, tbl[i].rpc);
            chk($sformatf("row%0d pc", i), imem_pc, tbl[i].pc);
            chk($sformatf("row%0d valid", i), {63'd0, if_id_valid}, {63'd0, tbl[i].v});
            chk($sformatf("row%0d instr", i), {32'd0, if_id_instr}, {32'd0, tbl[i].ins});
            chk($sformatf("row%0d cnt", i), {32'd0, fetch_count}, {32'd0, tbl[i].cnt});
            chk($sformatf("row%0d halted", i), {63'd0, halted}, {63'd0, tbl[i].h});
            chk($sformatf("row%0d mis", i), {63'd0, misaligned}, {63'd0, tbl[i].m});
            if (tbl[i].v || tbl[i].r) chk($sformatf("row%0d ifpc", i), if_id_pc, tbl[i].ipc);
        end

        // asynchronous reset mid-cycle clears everything, including sticky misaligned
        step(1'b0, 1'b0, 64'h0);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("async1");
        @(negedge clk) rst_n = 1'b1;
        mem[5] = a(5);
        repeat (7) step(1'b0, 1'b0, 64'h0);
        chk("run7 pc", imem_pc, 64'h1C);
        chk("run7 cnt", {32'd0, fetch_count}, 64'd7);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("async2");
        @(negedge clk) rst_n = 1'b1;

        // randomized run against a rule-level model
        for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
        m_pc = 0; m_ipc = 0; m_ins = 32'h13; m_cnt = 0; m_v = 0; m_h = 0; m_m = 0;
        for (int c = 0; c < 800; c++) begin
            logic s, r;
            logic [63:0] t;
            logic [31:0] w;
            s = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 7) == 0);
            t = {($urandom_range(0, 15) == 0) ? 54'h3F_FFFF_FFFF_FFFF : 54'd0, 10'($urandom_range(0, 1023))};
            w = mem[m_pc[9:2]];
            step(s, r, t);
            if (r) begin
                m_pc = t & ~64'd3; m_v = 0; m_ins = 32'h13; m_ipc = 0; m_h = 0;
                if (t % 4 != 0) m_m = 1;
            end else if (!s) begin
                if (m_h || w == 32'h0) begin
                    m_h = 1; m_v = 0; m_ins = 32'h13;
                end else begin
                    m_ipc = m_pc; m_ins = w; m_v = 1; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
                end
            end
            chk("rnd pc", imem_pc, m_pc);
            chk("rnd valid", {63'd0, if_id_valid}, {63'd0, m_v});
            chk("rnd instr", {32'd0, if_id_instr}, {32'd0, m_ins});
            chk("rnd cnt", {32'd0, fetch_count}, {32'd0, m_cnt});
            chk("rnd halted", {63'd0, halted}, {63'd0, m_h});
            chk("rnd mis", {63'd0, misaligned}, {63'd0, m_m});
            if (m_v) chk("rnd ifpc", if_id_pc, m_ipc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline. Owns the program counter and drives the word-addressed instruction memory combinationally.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles hazard-unit stalls, branch/jump redirects from EX, and a halt sentinel that stops fetching.
- Keeps a retired-fetch counter for performance debug.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble encoding written into IF/ID on flush, halt, or reset.
- HALT_INSTR, 32'h00000000, fetched encoding that stops fetch.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- imem_pc  output  64  current PC to instruction memory, equals pc register (combinational)
- imem_instr  input  32  instruction returned combinationally for imem_pc in the same cycle
- stall  input  1  hazard unit: hold PC and IF/ID
- redirect  input  1  EX resolved taken branch/jump
- redirect_pc  input  64  target PC for redirect
- if_id_pc  output  64  PC of the instruction held in IF/ID
- if_id_instr  output  32  instruction held in IF/ID
- if_id_valid  output  1  IF/ID holds a real instruction
- halted  output  1  fetch stopped on HALT_INSTR
- misaligned  output  1  sticky flag: a redirect target had bits [1:0] != 0
- fetch_count  output  32  number of instructions written into IF/ID with valid=1

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC; state=RUN.
  - if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - halted=0, misaligned=0, fetch_count=0.
  - Reset asserted mid-operation overrides everything in the same instant.
- State machine RUN/HALTED; halted=1 exactly when state=HALTED. Per-edge priority: redirect > stall > halt detect > normal fetch.
- Redirect (either state):
  - pc <= {redirect_pc[63:2],2'b00}.
  - IF/ID flushed: if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0.
  - state <= RUN; stall is ignored that cycle.
  - If redirect_pc[1:0]!=0, misaligned <= 1; it stays set until reset.
- Stall without redirect: pc, IF/ID, state and fetch_count all hold.
- RUN, no stall/redirect, imem_instr==HALT_INSTR:
  - state <= HALTED; pc holds at the halt address.
  - IF/ID gets a bubble (valid=0, NOP_INSTR); the halt word is never forwarded.
- RUN, no stall/redirect, normal fetch:
  - if_id_pc <= pc, if_id_instr <= imem_instr, if_id_valid <= 1.
  - pc <= pc+4, wrapping modulo 2^64.
  - fetch_count <= fetch_count+1, wrapping at 2^32.
- HALTED, no redirect: pc holds; IF/ID loads a bubble each non-stalled edge; fetch_count holds.
- Latency: an instruction at PC p appears in IF/ID one edge after pc==p with no stall.
- imem_pc is the raw pc; the memory applies the >>2 word index. PC beyond the memory size is not checked here.

Test Plan:
- Reset, then 4 free-running cycles with memory words 0..3 = A,B,C,D -> if_id_pc 0,4,8,12 with instr A..D, if_id_valid=1, fetch_count=4.
- stall high for 2 cycles while pc=8 -> pc stays 8, IF/ID keeps (4,B), fetch_count unchanged; fetch resumes with (8,C).
- redirect=1, redirect_pc=0x40, with stall=1 in the same cycle -> next pc=0x40, if_id_valid=0, if_id_instr=32'h13; next edge IF/ID=(0x40, word16).
- redirect_pc=0x42 -> pc=0x40, misaligned=1; the flag stays 1 after later redirects; reset clears it.
- Word 5=HALT_INSTR -> after the PC=20 edge halted=1, pc holds at 20, if_id_valid=0 thereafter; redirect to 0 -> halted=0 and fetch resumes at 0.
- Drop rst_n asynchronously mid-run with pc=0x1C, count=7 -> pc=RESET_PC, all IF/ID outputs, halted and fetch_count reset immediately, before the next edge.
